// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot/binary grant, zero-bubble handoff
// and a per-owner hold limit that forces rotation under sustained contention.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [N-1:0]     r_gnt;

  logic             w_idle_hit, w_rot_hit, w_own_req;
  logic [IDX_W-1:0] w_idle_idx, w_rot_idx, w_owner_inc;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N - 1)) ? '0 : x + IDX_W'(1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] x);
    logic [N-1:0] oh;
    oh = '0;
    for (int k = 0; k < N; k++) oh[k] = (IDX_W'(k) == x);
    return oh;
  endfunction

  // First set bit among 'span' positions starting at 'start', wrapping modulo N.
  function automatic logic [IDX_W:0] find_first(input logic [N-1:0] req,
                                                input logic [IDX_W-1:0] start,
                                                input int span);
    logic             hit;
    logic [IDX_W-1:0] idx;
    int               pos;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!hit && k < span && req[pos]) begin
        hit = 1'b1;
        idx = IDX_W'(pos);
      end
    end
    return {hit, idx};
  endfunction

  assign w_owner_inc             = wrap_inc(r_owner);
  assign w_own_req               = |(req_i & onehot(r_owner));
  assign {w_idle_hit, w_idle_idx} = find_first(req_i, r_ptr, N);
  // Span N-1 from owner+1 never reaches the owner itself.
  assign {w_rot_hit, w_rot_idx}   = find_first(req_i, w_owner_inc, N - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_idle_hit) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_idle_idx;
          w_hold_nxt  = HW'(1);
          w_ptr_nxt   = wrap_inc(w_idle_idx);
        end
      end
      GRANT: begin
        if (w_own_req && r_hold < HW'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + HW'(1);
        end else if (w_rot_hit) begin
          w_owner_nxt = w_rot_idx;
          w_hold_nxt  = HW'(1);
          w_ptr_nxt   = wrap_inc(w_rot_idx);
        end else if (w_own_req) begin
          w_hold_nxt = HW'(1);
          w_ptr_nxt  = w_owner_inc;
        end else begin
          w_state_nxt = IDLE;
          w_owner_nxt = '0;
          w_hold_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= (w_state_nxt == GRANT) ? onehot(w_owner_nxt) : '0;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_owner;
  assign gnt_valid_o = (r_state == GRANT);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios plus random traffic on an
// N=4 and an N=5 instance, both checked against a rule-level reference model.
module tb_round_robin_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req4, g4;
  logic [1:0] i4;
  logic       v4;
  logic [4:0] req5, g5;
  logic [2:0] i5;
  logic       v5;

  int checks = 0, failures = 0;
  int m_own[2], m_hold[2], m_ptr[2];
  int m_wait[2][16];

  always #5 clk = ~clk;

  round_robin_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4),
    .gnt_o(g4), .gnt_idx_o(i4), .gnt_valid_o(v4));

  round_robin_arbiter #(.N(5), .IDX_W(3), .MAX_HOLD(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_i(req5),
    .gnt_o(g5), .gnt_idx_o(i5), .gnt_valid_o(v5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner -1 means no owner.
  task automatic mdl(input int u, input int n, input int mh, input logic [15:0] req,
                     input logic rs);
    int  nw;
    bit  found;
    if (!rs) begin
      m_own[u] = -1; m_hold[u] = 0; m_ptr[u] = 0;
      return;
    end
    if (m_own[u] < 0) begin
      for (int k = 0; k < n; k++) begin
        nw = (m_ptr[u] + k) % n;
        if (req[nw]) begin
          m_own[u] = nw; m_hold[u] = 1; m_ptr[u] = (nw + 1) % n;
          break;
        end
      end
    end else if (req[m_own[u]] && m_hold[u] < mh) begin
      m_hold[u]++;
    end else begin
      found = 0;
      nw = 0;
      for (int k = 1; k < n; k++) begin
        nw = (m_own[u] + k) % n;
        if (req[nw]) begin found = 1; break; end
      end
      if (found) begin
        m_own[u] = nw; m_hold[u] = 1; m_ptr[u] = (nw + 1) % n;
      end else if (req[m_own[u]]) begin
        m_hold[u] = 1; m_ptr[u] = (m_own[u] + 1) % n;
      end else begin
        m_own[u] = -1; m_hold[u] = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] r4, input logic rs);
    logic [4:0] r5;
    int         worst4, worst5;
    r5 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : req5;
    req4 = r4; req5 = r5; rst_n = rs;
    @(posedge clk); #1;
    mdl(0, 4, 4, {12'b0, r4}, rs);
    mdl(1, 5, 3, {11'b0, r5}, rs);
    chk("gnt4",   {28'b0, g4}, (m_own[0] < 0) ? 0 : (32'd1 << m_own[0]));
    chk("idx4",   {30'b0, i4}, (m_own[0] < 0) ? 0 : m_own[0]);
    chk("vld4",   {31'b0, v4}, (m_own[0] < 0) ? 0 : 1);
    chk("gnt5",   {27'b0, g5}, (m_own[1] < 0) ? 0 : (32'd1 << m_own[1]));
    chk("idx5",   {29'b0, i5}, (m_own[1] < 0) ? 0 : m_own[1]);
    chk("vld5",   {31'b0, v5}, (m_own[1] < 0) ? 0 : 1);
    chk("unreq4", {28'b0, g4 & ~r4}, 0);
    chk("unreq5", {27'b0, g5 & ~r5}, 0);
    worst4 = 0; worst5 = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        if (!rs || !r4[k] || g4[k]) m_wait[0][k] = 0; else m_wait[0][k]++;
        if (m_wait[0][k] > worst4) worst4 = m_wait[0][k];
      end
      if (!rs || !r5[k] || g5[k]) m_wait[1][k] = 0; else m_wait[1][k]++;
      if (m_wait[1][k] > worst5) worst5 = m_wait[1][k];
    end
    chk("starve4", {31'b0, worst4 > 3 * 4 + 1}, 0);
    chk("starve5", {31'b0, worst5 > 4 * 3 + 1}, 0);
  endtask

  function automatic int first_from(input logic [3:0] pat, input int p);
    for (int k = 0; k < 4; k++)
      if (pat[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    int         e;
    logic [3:0] r;
    req4 = '0; req5 = '0; rst_n = 1'b0;
    for (int s = 0; s < 16; s++) begin m_wait[0][s] = 0; m_wait[1][s] = 0; end

    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("rst_gnt", {28'b0, g4}, 0);
    chk("rst_vld", {31'b0, v4}, 0);

    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 1'b1);
      chk("idle_gnt", {28'b0, g4}, 0);
      chk("idle_vld", {31'b0, v4}, 0);
    end

    step(4'b0000, 1'b0);
    step(4'b1010, 1'b1);
    chk("pick1_gnt", {28'b0, g4}, 32'h2);
    chk("pick1_idx", {30'b0, i4}, 1);
    step(4'b1000, 1'b1);
    chk("handoff_gnt", {28'b0, g4}, 32'h8);
    chk("handoff_idx", {30'b0, i4}, 3);

    step(4'b0000, 1'b0);
    for (int c = 0; c < 17; c++) begin
      step(4'b1111, 1'b1);
      chk("rot_gnt", {28'b0, g4}, 32'd1 << ((c / 4) % 4));
    end

    step(4'b0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(4'b0100, 1'b1);
      chk("solo_gnt", {28'b0, g4}, 32'h4);
      chk("solo_vld", {31'b0, v4}, 1);
    end
    step(4'b0100, 1'b0);
    chk("midrst_gnt", {28'b0, g4}, 0);
    chk("midrst_idx", {30'b0, i4}, 0);
    chk("midrst_vld", {31'b0, v4}, 0);
    step(4'b0101, 1'b1);
    chk("postrst_gnt", {28'b0, g4}, 32'h1);

    // Park the pointer at p by granting p-1 and releasing to IDLE.
    for (int p = 0; p < 4; p++) begin
      for (int pat = 0; pat < 16; pat++) begin
        step(4'b0000, 1'b1);
        r = 4'(1 << ((p + 3) % 4));
        step(r, 1'b1);
        step(4'b0000, 1'b1);
        r = 4'(pat);
        step(r, 1'b1);
        e = first_from(r, p);
        chk("sweep_gnt", {28'b0, g4}, (e < 0) ? 0 : (32'd1 << e));
        chk("sweep_idx", {30'b0, i4}, (e < 0) ? 0 : e);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : req4;
      step(r, $urandom_range(0, 63) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
